// File: rtl/matrix_r_unloader_pkg.sv
// Shared definitions for the matrix R drain logic.
//   - Default geometry (element width, lanes per word, address width)
//   - FSM state encoding
//   - Header word addresses (a, c, R_start)
//   - lane_lsb(): bit offset of lane k inside a packed memory word
package matrix_r_unloader_pkg;

  localparam int REG_WIDTH_DEF           = 12;
  localparam int CORE_COUNT_DEF          = 4;
  localparam int DATA_MEM_ADDR_WIDTH_DEF = 12;

  localparam int A_ADDR       = 0;
  localparam int C_ADDR       = 2;
  localparam int R_START_ADDR = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } state_e;

  // Lane 0 (row 0 of a block) sits in the most significant lane.
  function automatic int lane_lsb(input int k, input int reg_width, input int core_count);
    return (core_count - 1 - k) * reg_width;
  endfunction

endpackage

// File: rtl/matrix_r_unloader_lane_extract.sv
// lane_extract: combinational CORE_COUNT:1 lane mux.
// Ports:
//   word_i  - packed memory word, CORE_COUNT lanes of REG_WIDTH bits
//   lane_i  - lane index k (0 = most significant lane)
//   elem_o  - selected lane
module lane_extract
  import matrix_r_unloader_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int CORE_COUNT = CORE_COUNT_DEF,
  parameter int KW         = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
  input  logic [REG_WIDTH*CORE_COUNT-1:0] word_i,
  input  logic [KW-1:0]                   lane_i,
  output logic [REG_WIDTH-1:0]            elem_o
);

  always_comb begin
    elem_o = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (lane_i == KW'(k)) begin
        elem_o = word_i[lane_lsb(k, REG_WIDTH, CORE_COUNT) +: REG_WIDTH];
      end
    end
  end

endmodule

// File: rtl/matrix_r_unloader.sv
// matrix_r_unloader: after start, reads the a/c/R_start header words, then
// walks the lane-packed result matrix R and streams it row-major, one
// element per valid/ready transfer.
// Ports:
//   clk, rstN            - clock, asynchronous active-low reset
//   start                - begin a drain (only honoured when idle)
//   memAddr / memDataIn  - data memory read port (2-edge read latency)
//   outData/outValid/outReady/outLast - element stream
//   busy                 - block owns the memory read port
//   done                 - one-cycle completion pulse
module matrix_r_unloader
  import matrix_r_unloader_pkg::*;
#(
  parameter int REG_WIDTH           = REG_WIDTH_DEF,
  parameter int CORE_COUNT          = CORE_COUNT_DEF,
  parameter int DATA_MEM_ADDR_WIDTH = DATA_MEM_ADDR_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            start,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]  memAddr,
  input  logic [REG_WIDTH*CORE_COUNT-1:0] memDataIn,
  output logic [REG_WIDTH-1:0]            outData,
  output logic                            outValid,
  input  logic                            outReady,
  output logic                            outLast,
  output logic                            busy,
  output logic                            done
);

  localparam int KW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int AW = DATA_MEM_ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [1:0]            hdrCnt_q, hdrCnt_d;
  logic                  wait_q, wait_d;
  logic [REG_WIDTH-1:0]  a_q, a_d, c_q, c_d;
  logic [REG_WIDTH-1:0]  rowBase_q, rowBase_d, row_q, row_d, z_q, z_d;
  logic [KW-1:0]         lane_q, lane_d;
  logic [AW-1:0]         memAddr_q, memAddr_d;
  logic [REG_WIDTH-1:0]  outData_q, outData_d;
  logic                  outValid_q, outValid_d, outLast_q, outLast_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [REG_WIDTH-1:0]  hdrWord, laneElem;
  logic [REG_WIDTH-1:0]  zN, rowN, rowBaseN;
  logic [KW-1:0]         laneN;
  logic                  lastCol, isLast;

  assign hdrWord = memDataIn[REG_WIDTH-1:0];

  lane_extract #(
    .REG_WIDTH  (REG_WIDTH),
    .CORE_COUNT (CORE_COUNT),
    .KW         (KW)
  ) u_lane_extract (
    .word_i (memDataIn),
    .lane_i (lane_q),
    .elem_o (laneElem)
  );

  // Position of the element after the current one: next column, else next
  // row; leaving the bottom lane of a block moves rowBase on by one block (c).
  always_comb begin
    lastCol  = (z_q == c_q - 1'b1);
    isLast   = lastCol && (row_q == a_q - 1'b1);
    zN       = z_q + 1'b1;
    rowN     = row_q;
    laneN    = lane_q;
    rowBaseN = rowBase_q;
    if (lastCol) begin
      zN   = '0;
      rowN = row_q + 1'b1;
      if (lane_q == KW'(CORE_COUNT - 1)) begin
        laneN    = '0;
        rowBaseN = rowBase_q + c_q;
      end else begin
        laneN = lane_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hdrCnt_d   = hdrCnt_q;
    wait_d     = wait_q;
    a_d        = a_q;
    c_d        = c_q;
    rowBase_d  = rowBase_q;
    row_d      = row_q;
    z_d        = z_q;
    lane_d     = lane_q;
    memAddr_d  = memAddr_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HDR;
          hdrCnt_d  = '0;
          memAddr_d = AW'(A_ADDR);
          busy_d    = 1'b1;
        end
      end
      // Header reads are pipelined: each address is issued one edge after
      // the previous, and its data arrives two edges later.
      ST_HDR: begin
        hdrCnt_d = hdrCnt_q + 1'b1;
        case (hdrCnt_q)
          2'd0: memAddr_d = AW'(C_ADDR);
          2'd1: begin
            memAddr_d = AW'(R_START_ADDR);
            a_d       = hdrWord;
          end
          2'd2: c_d = hdrWord;
          default: begin
            rowBase_d = hdrWord;
            row_d     = '0;
            z_d       = '0;
            lane_d    = '0;
            if (a_q == '0 || c_q == '0) begin
              // Empty matrix: busy stays up through FIN and drops with done.
              state_d = ST_FIN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
          end
        endcase
      end
      ST_FETCH: begin
        memAddr_d = AW'(rowBase_q + z_q);
        wait_d    = 1'b0;
        state_d   = ST_WAIT;
      end
      // Two edges after the address is issued the element word is present.
      ST_WAIT: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          outData_d  = laneElem;
          outValid_d = 1'b1;
          outLast_d  = isLast;
          state_d    = ST_SEND;
        end
      end
      // The next address is issued on the transfer edge itself, so the
      // next element needs only the two latency edges of WAIT.
      ST_SEND: begin
        if (outReady) begin
          outValid_d = 1'b0;
          outLast_d  = 1'b0;
          if (isLast) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            z_d       = zN;
            row_d     = rowN;
            lane_d    = laneN;
            rowBase_d = rowBaseN;
            memAddr_d = AW'(rowBaseN + zN);
            wait_d    = 1'b0;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_IDLE;
      hdrCnt_q   <= '0;
      wait_q     <= 1'b0;
      a_q        <= '0;
      c_q        <= '0;
      rowBase_q  <= '0;
      row_q      <= '0;
      z_q        <= '0;
      lane_q     <= '0;
      memAddr_q  <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdrCnt_q   <= hdrCnt_d;
      wait_q     <= wait_d;
      a_q        <= a_d;
      c_q        <= c_d;
      rowBase_q  <= rowBase_d;
      row_q      <= row_d;
      z_q        <= z_d;
      lane_q     <= lane_d;
      memAddr_q  <= memAddr_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign memAddr  = memAddr_q;
  assign outData  = outData_q;
  assign outValid = outValid_q;
  assign outLast  = outLast_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_matrix_r_unloader.sv
// Bench for matrix_r_unloader: directed table vectors, randomized matrices
// against a row-major reference model, and a reset/abort sequence.
module tb_matrix_r_unloader;

  localparam int W  = 12;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstN, start, outReady;
  logic [AW-1:0] memAddr;
  logic [W*N-1:0] memDataIn;
  logic [W-1:0]  outData;
  logic          outValid, outLast, busy, done;

  logic [W*N-1:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  // Registered memory: data for an address appears two edges after it is issued.
  always @(posedge clk) memDataIn <= mem[memAddr];

  matrix_r_unloader #(
    .REG_WIDTH           (W),
    .CORE_COUNT          (N),
    .DATA_MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .memAddr   (memAddr),
    .memDataIn (memDataIn),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .outLast   (outLast),
    .busy      (busy),
    .done      (done)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_d[$];
  logic         exp_l[$];

  typedef struct {
    int             a;
    int             c;
    int             rs;
    logic [W*N-1:0] w0;
    logic [W*N-1:0] w1;
    int             stall_idx;
    int             n;
    logic [0:5][W-1:0] e;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic set_hdr(input int a, input int c, input int rs);
    logic [31:0] av, cv, rv;
    av = a; cv = c; rv = rs;
    mem[0][W-1:0] = av[W-1:0];
    mem[2][W-1:0] = cv[W-1:0];
    mem[5][W-1:0] = rv[W-1:0];
  endtask

  // Reference: enumerate R in output order straight from the layout rule.
  task automatic build_model(input int a, input int c, input int rs);
    int total, n;
    exp_d.delete();
    exp_l.delete();
    total = a * c;
    n = 0;
    for (int x = 0; x * N < a; x++) begin
      for (int k = 0; k < N; k++) begin
        if (x * N + k < a) begin
          for (int z = 0; z < c; z++) begin
            int addr;
            logic [W*N-1:0] wd;
            addr = (rs + x * c + z) % DEPTH;
            wd = mem[addr];
            exp_d.push_back(wd[(N - k) * W - 1 -: W]);
            n++;
            exp_l.push_back(n == total);
          end
        end
      end
    end
  endtask

  task automatic run_stream(input int stall_idx, input bit rand_ready,
                            input int glitch_cyc, input int abort_after);
    int cyc, idx, stalled, last_xfer, busy_cyc, nexp;
    bit hold, seen_valid, finished, rdy;
    logic [W-1:0] hold_d;
    logic hold_l;
    cyc = 0; idx = 0; stalled = 0; last_xfer = -1; busy_cyc = 0;
    hold = 0; seen_valid = 0; finished = 0; hold_d = '0; hold_l = 0;
    nexp = exp_d.size();
    outReady = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!finished) begin
      if (cyc > 1500) begin
        chk("stream_timeout", 1, 0);
        finished = 1;
      end else begin
        start = (cyc == glitch_cyc);
        if (busy) busy_cyc++;
        if (hold) begin
          chk("hold_valid", int'(outValid), 1);
          chk("hold_data", int'(outData), int'(hold_d));
          chk("hold_last", int'(outLast), int'(hold_l));
        end
        if (outValid && !seen_valid) begin
          seen_valid = 1;
          chk("first_valid_latency", cyc, 7);
        end
        if (done) begin
          chk("elements_before_done", idx, nexp);
          if (nexp == 0) begin
            chk("empty_done_time", cyc, 4);
            chk("empty_busy_cycles", busy_cyc, 5);
            chk("empty_no_valid", int'(seen_valid), 0);
          end else begin
            chk("done_time", cyc, last_xfer + 1);
            chk("busy_at_done", int'(busy), 0);
            chk("valid_at_done", int'(outValid), 0);
          end
          tick();
          chk("done_pulse_width", int'(done), 0);
          chk("busy_after_done", int'(busy), 0);
          finished = 1;
        end else begin
          if (outValid && idx == stall_idx && stalled < 5) begin
            rdy = 0;
            stalled++;
          end else if (rand_ready) begin
            rdy = ($urandom_range(0, 2) != 0);
          end else begin
            rdy = 1;
          end
          outReady = rdy;
          if (outValid && rdy) begin
            if (idx < nexp) begin
              chk("elem_data", int'(outData), int'(exp_d[idx]));
              chk("elem_last", int'(outLast), int'(exp_l[idx]));
            end else begin
              chk("extra_element", 1, 0);
            end
            if (!rand_ready && stall_idx < 0 && last_xfer >= 0)
              chk("xfer_interval", cyc - last_xfer, 3);
            last_xfer = cyc;
            idx++;
            hold = 0;
            if (idx == abort_after) finished = 1;
          end else begin
            hold   = outValid;
            hold_d = outData;
            hold_l = outLast;
          end
          if (!finished) begin
            tick();
            cyc++;
          end
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic load_vec(input int i);
    fill_random();
    mem[tbl[i].rs % DEPTH]       = tbl[i].w0;
    mem[(tbl[i].rs + 1) % DEPTH] = tbl[i].w1;
    set_hdr(tbl[i].a, tbl[i].c, tbl[i].rs);
    exp_d.delete();
    exp_l.delete();
    for (int j = 0; j < tbl[i].n; j++) begin
      exp_d.push_back(tbl[i].e[j]);
      exp_l.push_back(j == tbl[i].n - 1);
    end
  endtask

  initial begin
    tbl[0] = '{3, 2, 'h010, {12'h001, 12'h002, 12'h003, 12'h000},
               {12'h004, 12'h005, 12'h006, 12'h000}, -1, 6,
               {12'h001, 12'h004, 12'h002, 12'h005, 12'h003, 12'h006}};
    tbl[1] = '{5, 1, 'h020, {12'h00A, 12'h00B, 12'h00C, 12'h00D},
               {12'h00E, 12'h777, 12'h777, 12'h777}, -1, 5,
               {12'h00A, 12'h00B, 12'h00C, 12'h00D, 12'h00E, 12'h000}};
    tbl[2] = '{3, 2, 'h010, {12'h001, 12'h002, 12'h003, 12'h000},
               {12'h004, 12'h005, 12'h006, 12'h000}, 1, 6,
               {12'h001, 12'h004, 12'h002, 12'h005, 12'h003, 12'h006}};
    tbl[3] = '{0, 4, 'h010, {12'h001, 12'h002, 12'h003, 12'h004},
               {12'h005, 12'h006, 12'h007, 12'h008}, -1, 0,
               {12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000}};
    tbl[4] = '{2, 2, 'hFFF, {12'h0C1, 12'h0C2, 12'h0C3, 12'h0C4},
               {12'h0A1, 12'h0B2, 12'h000, 12'h002}, -1, 4,
               {12'h0C1, 12'h0A1, 12'h0C2, 12'h0B2, 12'h000, 12'h000}};

    rstN = 1'b0; start = 1'b0; outReady = 1'b0;
    fill_random();
    tick(); tick();
    chk("rst_memAddr", int'(memAddr), 0);
    chk("rst_outData", int'(outData), 0);
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_outLast", int'(outLast), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rstN = 1'b1;
    tick(); tick();

    for (int i = 0; i < 5; i++) begin
      load_vec(i);
      run_stream(tbl[i].stall_idx, 1'b0, -1, -1);
      tick(); tick();
    end

    for (int it = 0; it < 12; it++) begin
      int a, c, rs;
      a  = $urandom_range(0, 9);
      c  = $urandom_range(0, 4);
      rs = (it % 2 == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
      fill_random();
      set_hdr(a, c, rs);
      build_model(a, c, rs);
      run_stream(-1, it[0], -1, -1);
      tick(); tick();
    end

    // Mid-stream: an extra start is ignored, then reset abandons the stream.
    load_vec(0);
    run_stream(-1, 1'b0, 9, 3);
    tick();
    chk("pre_reset_busy", int'(busy), 1);
    #2 rstN = 1'b0;
    #1;
    chk("async_rst_memAddr", int'(memAddr), 0);
    chk("async_rst_outData", int'(outData), 0);
    chk("async_rst_outValid", int'(outValid), 0);
    chk("async_rst_outLast", int'(outLast), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    tick(); tick();
    rstN = 1'b1;
    tick(); tick();
    chk("post_reset_idle_busy", int'(busy), 0);
    chk("post_reset_idle_done", int'(done), 0);
    run_stream(-1, 1'b0, -1, -1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
